div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage, beside the combinational ALU.
- Takes over RV32M DIV/DIVU/REM/REMU so the ALU keeps no combinational divider.
- Decode/hazard logic issues operands with Start and holds the pipeline while Busy.
- Result goes to the same EX/MEM writeback mux input as the ALU Result.

Parameters:
- DATA_LEN, 32, operand/result width; only 32 is supported.
- ITER, 32, quotient bits produced, one per cycle; must equal DATA_LEN.

Ports:
- Clk  in  1  rising-edge clock.
- RstN  in  1  synchronous active-low reset.
- Start  in  1  request; sampled only while Busy=0.
- DivOp  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Dividend  in  32  rs1 value.
- Divisor  in  32  rs2 value.
- Flush  in  1  pipeline flush; aborts any operation.
- Busy  out  1  high in LOAD, CALC and FIX; hazard unit stalls on it.
- Valid  out  1  one-cycle pulse; Result is valid in the same cycle.
- Result  out  32  quotient or remainder per DivOp.

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (RstN=0 at an edge): state IDLE, Busy=0, Valid=0, Result=0, internal registers 0. Reset mid-operation discards the operation and produces no Valid.
- States: IDLE, LOAD, CALC, FIX, DONE. Busy and Valid are decoded from registered state only.
- IDLE/DONE, Start=1, Flush=0, special case: go to DONE with Result already computed (fast path).
- IDLE/DONE, Start=1, Flush=0, no special case: capture DivOp, operand signs, |Dividend|, |Divisor| (signed ops) or raw values (unsigned ops); go to LOAD.
- DONE with no Start: go to IDLE.
- LOAD: clear the 33-bit partial remainder; load the quotient register with the magnitude dividend; counter=0; go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor.
  - trial >= 0: rem=trial, quo[0]=1; otherwise restore rem, quo[0]=0.
  - After 32 iterations (counter 31) go to FIX.
- FIX:
  - Signed quotient negated if the dividend and divisor signs differ.
  - Signed remainder takes the dividend's sign.
  - Select quotient or remainder per DivOp; register into Result; go to DONE.
- DONE: Valid=1 for exactly one cycle; Result holds its value until the next Valid.
- Latency, with Start sampled at the end of cycle 0:
  - General case: Valid in cycle 35 (LOAD 1, CALC 2-33, FIX 34, DONE 35).
  - Fast path: Valid in cycle 1.
- Special cases (fast path), RISC-V semantics:
  - Divisor=0: quotient=32'hFFFF_FFFF for DIV and DIVU; remainder=Dividend for REM and REMU.
  - Signed overflow (Dividend=32'h8000_0000, Divisor=32'hFFFF_FFFF, DIV/REM only): quotient=32'h8000_0000, remainder=0.
- Back-to-back: Start during a DONE cycle is accepted; the next operation begins with no IDLE gap.
- Start while Busy=1 is ignored; operands are not re-sampled.
- Operand inputs may change after the Start cycle; only the captured copies are used.
- Flush=1 at any edge forces IDLE. No Valid follows, and Flush has priority over a simultaneous Start.
- A Valid already registered into DONE still pulses in that cycle; the pipeline discards it.
- Magnitude of 32'h8000_0000 is handled as an unsigned 33-bit value; no overflow inside CALC.

Decomposition:
- Constants.vh gains the DIV_OP_DIV/DIVU/REM/REMU codes and DIV_OP_WIDTH; decode uses the same macros.
- A small package div_pkg holds typedef enum logic [2:0] div_state_t {IDLE, LOAD, CALC, FIX, DONE}.
- One sub-module, div_step, is natural: a combinational single iteration.
  - Inputs: {rem, quo}, divisor.
  - Outputs: next {rem, quo}.
  - Unit-testable on its own.

Test Plan:
- DIVU 100/7, Start one cycle -> Busy cycles 1-34; Valid only in cycle 35; Result=14. REMU 100/7 -> Result=2.
- DIV -7/2 -> Result=32'hFFFF_FFFD (-3). REM -7/2 -> Result=32'hFFFF_FFFF (-1). REM 7/-2 -> Result=1.
- Divide by zero: DIV 5/0 -> Valid in cycle 1, Result=32'hFFFF_FFFF. REMU 5/0 -> Result=5.
- Overflow: DIV 32'h8000_0000 / -1 -> Valid in cycle 1, Result=32'h8000_0000. REM of the same operands -> Result=0.
- Start DIVU 10/3 during the DONE cycle of a prior op -> second Valid 35 cycles later, Result=3. A Start pulse at cycle 10 is ignored and does not change that Result.
- Flush at cycle 12 mid-CALC -> IDLE at cycle 13, Busy=0, no Valid. RstN=0 at cycle 20 of a new op -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and opcode constants for the iterative divider.
package div_pkg;

    localparam int unsigned DIV_OP_WIDTH = 2;

    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'b10;
    localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Low opcode bit clear means the operation is signed (DIV, REM).
    function automatic logic is_signed_op(input logic [DIV_OP_WIDTH-1:0] op);
        return ~op[0];
    endfunction

    // High opcode bit set selects the remainder (REM, REMU).
    function automatic logic is_rem_op(input logic [DIV_OP_WIDTH-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, try subtracting the divisor.
module div_step #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic [DATA_LEN:0]   rem,
    input  logic [DATA_LEN-1:0] quo,
    input  logic [DATA_LEN-1:0] divisor,
    output logic [DATA_LEN:0]   rem_next,
    output logic [DATA_LEN-1:0] quo_next
);

    logic [DATA_LEN+1:0] shifted;
    logic [DATA_LEN+1:0] trial;
    logic                fits;

    // Trial subtraction one bit wider than the remainder so the top bit is a clean sign.
    always_comb begin
        shifted  = {rem, quo[DATA_LEN-1]};
        trial    = shifted - (DATA_LEN+2)'(divisor);
        fits     = ~trial[DATA_LEN+1];
        rem_next = fits ? trial[DATA_LEN:0] : shifted[DATA_LEN:0];
        quo_next = {quo[DATA_LEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ITER     = 32
) (
    input  logic                    Clk,
    input  logic                    RstN,
    input  logic                    Start,
    input  logic [DIV_OP_WIDTH-1:0] DivOp,
    input  logic [DATA_LEN-1:0]     Dividend,
    input  logic [DATA_LEN-1:0]     Divisor,
    input  logic                    Flush,
    output logic                    Busy,
    output logic                    Valid,
    output logic [DATA_LEN-1:0]     Result
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam logic [DATA_LEN-1:0] INT_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

    div_state_t              state;
    logic [DIV_OP_WIDTH-1:0] op;
    logic                    sign_a;
    logic                    sign_b;
    logic [DATA_LEN-1:0]     dvd;
    logic [DATA_LEN-1:0]     dvs;
    logic [DATA_LEN:0]       rem;
    logic [DATA_LEN-1:0]     quo;
    logic [CNT_W-1:0]        cnt;

    logic [DATA_LEN:0]       step_rem;
    logic [DATA_LEN-1:0]     step_quo;

    logic                    in_signed;
    logic                    in_rem;
    logic                    special;
    logic [DATA_LEN-1:0]     special_result;
    logic [DATA_LEN-1:0]     abs_dividend;
    logic [DATA_LEN-1:0]     abs_divisor;
    logic [DATA_LEN-1:0]     fix_result;

    div_step #(
        .DATA_LEN (DATA_LEN)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Busy and Valid are pure decodes of the state register.
    assign Busy  = (state == LOAD) || (state == CALC) || (state == FIX);
    assign Valid = (state == DONE);

    // Issue-side decode: RISC-V special cases and operand magnitudes.
    always_comb begin
        in_signed      = is_signed_op(DivOp);
        in_rem         = is_rem_op(DivOp);
        special        = 1'b0;
        special_result = '0;
        if (Divisor == '0) begin
            special        = 1'b1;
            special_result = in_rem ? Dividend : '1;
        end else if (in_signed && (Dividend == INT_MIN) && (Divisor == '1)) begin
            special        = 1'b1;
            special_result = in_rem ? '0 : INT_MIN;
        end
        // Magnitude of INT_MIN wraps to itself, which is correct as an unsigned value.
        abs_dividend = (in_signed && Dividend[DATA_LEN-1]) ? ('0 - Dividend) : Dividend;
        abs_divisor  = (in_signed && Divisor[DATA_LEN-1])  ? ('0 - Divisor)  : Divisor;
    end

    // Sign correction of the unsigned quotient/remainder and result selection.
    always_comb begin
        fix_result = quo;
        if (is_rem_op(op)) begin
            fix_result = (is_signed_op(op) && sign_a) ? ('0 - rem[DATA_LEN-1:0]) : rem[DATA_LEN-1:0];
        end else if (is_signed_op(op) && (sign_a ^ sign_b)) begin
            fix_result = '0 - quo;
        end
    end

    // Control FSM and datapath registers; Flush beats any Start.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state  <= IDLE;
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            Result <= '0;
        end else if (Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        if (special) begin
                            Result <= special_result;
                            state  <= DONE;
                        end else begin
                            op     <= DivOp;
                            sign_a <= in_signed & Dividend[DATA_LEN-1];
                            sign_b <= in_signed & Divisor[DATA_LEN-1];
                            dvd    <= abs_dividend;
                            dvs    <= abs_divisor;
                            state  <= LOAD;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    rem   <= '0;
                    quo   <= dvd;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result <= fix_result;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
